// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette bank.
// Bank 0 boots with the standard tank palette.
package sprite_palette_pkg;

  localparam int PAL_ENTRIES = 16;

  localparam logic [11:0] DEFAULT_PALETTE [PAL_ENTRIES] = '{
    12'hF91, 12'hFFF, 12'h453, 12'h111, 12'h953, 12'hEB9, 12'hAA9, 12'hD52,
    12'h887, 12'h621, 12'h232, 12'hFD0, 12'hEED, 12'hD75, 12'h575, 12'hB21
  };

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

  function automatic rgb_t default_rgb(input logic [3:0] idx);
    return rgb_t'(DEFAULT_PALETTE[idx]);
  endfunction

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Pixel, palette-write and colour-output signals of the sprite palette bank.
// master drives pixels/writes and receives colour; slave is the palette block.
interface sprite_palette_bank_if #(
  parameter int IDX_W  = 4,
  parameter int BANK_W = 2,
  parameter int CH_W   = 4
);
  logic                frame_start;
  logic                pix_valid;
  logic [IDX_W-1:0]    pix_index;
  logic [BANK_W-1:0]   bank_req;
  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [IDX_W-1:0]    wr_index;
  logic [3*CH_W-1:0]   wr_rgb;
  logic                flash_trigger;
  logic [CH_W-1:0]     red;
  logic [CH_W-1:0]     green;
  logic [CH_W-1:0]     blue;
  logic                pix_valid_out;
  logic                transparent;
  logic [BANK_W-1:0]   active_bank;
  logic                flashing;

  modport master (
    output frame_start, pix_valid, pix_index, bank_req,
           wr_en, wr_bank, wr_index, wr_rgb, flash_trigger,
    input  red, green, blue, pix_valid_out, transparent, active_bank, flashing
  );

  modport slave (
    input  frame_start, pix_valid, pix_index, bank_req,
           wr_en, wr_bank, wr_index, wr_rgb, flash_trigger,
    output red, green, blue, pix_valid_out, transparent, active_bank, flashing
  );
endinterface

// File: rtl/sprite_flash_fsm.sv
// Hit-flash sequencer: alternates ON/OFF once per frame for FLASH_FRAMES frames.
// A trigger always reloads the frame count, even when it lands on a frame_start.
module sprite_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start_i,
  input  logic flash_trigger_i,
  output logic flash_on_o,
  output logic flashing_o
);

  localparam logic [7:0] RELOAD = 8'(FLASH_FRAMES);

  flash_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         flashing_q, flashing_d;

  // State, frame counter and flashing flag registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flashing_q <= flashing_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flash_trigger_i) begin
      state_d = FLASH_ON;
      cnt_d   = RELOAD;
    end else if (frame_start_i && (state_q != IDLE)) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q <= 8'd1) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end else begin
        case (state_q)
          FLASH_ON:  state_d = FLASH_OFF;
          FLASH_OFF: state_d = FLASH_ON;
          default:   state_d = IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Outputs
  always_comb begin
    flashing_d = (state_d != IDLE);
    flash_on_o = (state_q == FLASH_ON);
    flashing_o = flashing_q;
  end

endmodule

// File: rtl/sprite_palette_bank.sv
// Writable multi-bank sprite palette with frame-synchronised bank switching
// and hit-flash override; one registered lookup per cycle.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int BANKS        = 4,
  parameter int CH_W         = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sprite_palette_bank_if.slave  bus
);

  localparam int BANK_W  = $clog2(BANKS);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int RGB_W   = 3 * CH_W;

  logic [RGB_W-1:0]  mem_q [BANKS][ENTRIES];
  logic [BANK_W-1:0] pending_bank_q, active_bank_q;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              transparent_q, transparent_d;
  logic              valid_q;
  logic              flash_on;
  logic              flashing;

  sprite_flash_fsm #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_start_i   (bus.frame_start),
    .flash_trigger_i (bus.flash_trigger),
    .flash_on_o      (flash_on),
    .flashing_o      (flashing)
  );

  // Palette storage; non-blocking update gives read-before-write on collisions
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_q[b][e] <= RGB_W'(default_rgb(e[3:0]));
        end
      end
    end else if (bus.wr_en) begin
      mem_q[bus.wr_bank][bus.wr_index] <= bus.wr_rgb;
    end
  end

  // Colour selection for the pixel presented this cycle
  always_comb begin
    transparent_d = bus.pix_valid && (bus.pix_index == IDX_W'(TRANSP_IDX));
    if (!bus.pix_valid || transparent_d) begin
      rgb_d = '0;
    end else if (flash_on) begin
      rgb_d = '1;
    end else begin
      rgb_d = mem_q[active_bank_q][bus.pix_index];
    end
  end

  // Bank selection and output pipeline registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_bank_q <= '0;
      active_bank_q  <= '0;
      rgb_q          <= '0;
      transparent_q  <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      pending_bank_q <= bus.bank_req;
      if (bus.frame_start) begin
        active_bank_q <= pending_bank_q;
      end
      rgb_q          <= rgb_d;
      transparent_q  <= transparent_d;
      valid_q        <= bus.pix_valid;
    end
  end

  assign bus.red           = rgb_q[RGB_W-1 -: CH_W];
  assign bus.green         = rgb_q[2*CH_W-1 -: CH_W];
  assign bus.blue          = rgb_q[CH_W-1:0];
  assign bus.pix_valid_out = valid_q;
  assign bus.transparent   = transparent_q;
  assign bus.active_bank   = active_bank_q;
  assign bus.flashing      = flashing;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: expected pixels are queued when driven
// and compared one cycle later, with a 2-frame flash.
module tb_sprite_palette_bank;

  logic Clk = 1'b0;
  logic Reset;

  sprite_palette_bank_if #(.IDX_W(4), .BANK_W(2), .CH_W(4)) bus ();

  sprite_palette_bank #(
    .IDX_W(4), .BANKS(4), .CH_W(4), .TRANSP_IDX(0), .FLASH_FRAMES(2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [11:0] rgb;
    logic        transp;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Present one pixel, clock it, then compare the oldest queued expectation
  task automatic px(input logic v, input logic [3:0] idx, input logic [11:0] exp, input string tag);
    exp_t e;
    bus.pix_valid = v;
    bus.pix_index = idx;
    sb.push_back('{tag: tag, rgb: exp, transp: (v && idx == 4'd0), valid: v});
    @(posedge Clk);
    #1;
    bus.wr_en         = 1'b0;
    bus.frame_start   = 1'b0;
    bus.flash_trigger = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".rgb"}, {bus.red, bus.green, bus.blue}, e.rgb);
    chk({e.tag, ".transp"}, {11'd0, bus.transparent}, {11'd0, e.transp});
    chk({e.tag, ".valid"}, {11'd0, bus.pix_valid_out}, {11'd0, e.valid});
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_bank  = b;
    bus.wr_index = i;
    bus.wr_rgb   = d;
  endtask

  initial begin
    Reset             = 1'b1;
    bus.frame_start   = 1'b0;
    bus.pix_valid     = 1'b0;
    bus.pix_index     = 4'd0;
    bus.bank_req      = 2'd0;
    bus.wr_en         = 1'b0;
    bus.wr_bank       = 2'd0;
    bus.wr_index      = 4'd0;
    bus.wr_rgb        = 12'h000;
    bus.flash_trigger = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    chk("rst.valid", {11'd0, bus.pix_valid_out}, 12'd0);
    chk("rst.transp", {11'd0, bus.transparent}, 12'd0);
    chk("rst.bank", {10'd0, bus.active_bank}, 12'd0);
    chk("rst.flash", {11'd0, bus.flashing}, 12'd0);
    Reset = 1'b0;

    // Default lookups, transparency, invalid pixels
    px(1'b1, 4'd4, 12'h953, "idx4");
    px(1'b1, 4'd0, 12'h000, "transp");
    px(1'b0, 4'd5, 12'h000, "invalid");
    px(1'b1, 4'd15, 12'hB21, "idx15");

    // Program bank 2; switch only at frame_start
    wr(2'd2, 4'd4, 12'hABC);
    px(1'b1, 4'd4, 12'h953, "wr_b2");
    bus.bank_req = 2'd2;
    px(1'b1, 4'd4, 12'h953, "req_nofs");
    px(1'b1, 4'd4, 12'h953, "req_nofs2");
    chk("bank_held", {10'd0, bus.active_bank}, 12'd0);
    bus.frame_start = 1'b1;
    px(1'b1, 4'd4, 12'h953, "fs_edge");
    chk("bank_sw2", {10'd0, bus.active_bank}, 12'd2);
    px(1'b1, 4'd4, 12'hABC, "bank2");
    bus.bank_req = 2'd0;
    px(1'b1, 4'd4, 12'hABC, "req0");
    bus.frame_start = 1'b1;
    px(1'b1, 4'd4, 12'hABC, "fs_back");
    chk("bank_sw0", {10'd0, bus.active_bank}, 12'd0);

    // Read-before-write collision
    wr(2'd0, 4'd3, 12'h777);
    px(1'b1, 4'd3, 12'h111, "rbw_old");
    px(1'b1, 4'd3, 12'h777, "rbw_new");

    // Flash for two frames
    bus.flash_trigger = 1'b1;
    px(1'b1, 4'd4, 12'h953, "trig_edge");
    px(1'b1, 4'd4, 12'hFFF, "flash_on");
    chk("flashing_on", {11'd0, bus.flashing}, 12'd1);
    px(1'b1, 4'd0, 12'h000, "flash_transp");
    px(1'b0, 4'd4, 12'h000, "flash_invalid");
    bus.frame_start = 1'b1;
    px(1'b1, 4'd4, 12'hFFF, "fs1_edge");
    px(1'b1, 4'd4, 12'h953, "flash_off");
    chk("flashing_off", {11'd0, bus.flashing}, 12'd1);
    bus.frame_start = 1'b1;
    px(1'b1, 4'd4, 12'h953, "fs2_edge");
    px(1'b1, 4'd4, 12'h953, "flash_idle");
    chk("flashing_idle", {11'd0, bus.flashing}, 12'd0);

    // Trigger coinciding with frame_start reloads instead of decrementing
    bus.flash_trigger = 1'b1;
    px(1'b1, 4'd2, 12'h453, "rt_trig");
    bus.frame_start = 1'b1;
    px(1'b1, 4'd2, 12'hFFF, "rt_fs1");
    bus.flash_trigger = 1'b1;
    bus.frame_start   = 1'b1;
    px(1'b1, 4'd2, 12'h453, "rt_both");
    px(1'b1, 4'd2, 12'hFFF, "rt_reloaded");
    bus.frame_start = 1'b1;
    px(1'b1, 4'd2, 12'hFFF, "rt_fs2");
    px(1'b1, 4'd2, 12'h453, "rt_off");
    chk("rt_still_flashing", {11'd0, bus.flashing}, 12'd1);
    bus.frame_start = 1'b1;
    px(1'b1, 4'd2, 12'h453, "rt_fs3");
    px(1'b1, 4'd2, 12'h453, "rt_idle");
    chk("rt_flashing_idle", {11'd0, bus.flashing}, 12'd0);

    // Reset mid-flash after reprogramming bank 1; write in reset cycle dropped
    wr(2'd1, 4'd4, 12'h123);
    bus.flash_trigger = 1'b1;
    px(1'b1, 4'd4, 12'h953, "pre_rst");
    px(1'b1, 4'd4, 12'hFFF, "pre_rst_flash");
    Reset = 1'b1;
    wr(2'd1, 4'd5, 12'h0F0);
    bus.bank_req  = 2'd3;
    bus.pix_valid = 1'b1;
    bus.pix_index = 4'd4;
    @(posedge Clk);
    #1;
    Reset        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.bank_req = 2'd0;
    chk("mrst.rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    chk("mrst.valid", {11'd0, bus.pix_valid_out}, 12'd0);
    chk("mrst.flash", {11'd0, bus.flashing}, 12'd0);
    chk("mrst.bank", {10'd0, bus.active_bank}, 12'd0);
    bus.frame_start = 1'b1;
    px(1'b1, 4'd3, 12'h111, "mrst_b0_restored");
    chk("mrst.pending0", {10'd0, bus.active_bank}, 12'd0);
    bus.bank_req = 2'd1;
    px(1'b1, 4'd4, 12'h953, "req1");
    bus.frame_start = 1'b1;
    px(1'b1, 4'd4, 12'h953, "fs_b1");
    chk("bank_sw1", {10'd0, bus.active_bank}, 12'd1);
    px(1'b1, 4'd4, 12'h953, "b1_default");
    px(1'b1, 4'd5, 12'hEB9, "b1_dropped_wr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
